spi_header_serializer: RTL
==========================

Name: spi_header_serializer

Overview:
- Transmit-side counterpart of the SPI slave header receiver.
- Accepts a 6-bit header and a DWL-bit payload as one parallel frame.
- Shifts the frame out MSB-first on oMOSI, one bit per qualified iBIT_EN strobe.
- Generates the per-bit enable that the receiving header decoder uses as its shift enable, plus header-complete and frame-complete pulses.

Parameters:
- DWL, 16: payload width in bits; legal range 1..31.
- CWL, 5: bit-counter width; must satisfy 2^CWL >= max(6, DWL).

Ports:
- iCLK  input  1  system clock; all logic on the rising edge.
- iRSTn  input  1  synchronous active-low reset.
- iCLR  input  1  synchronous clear; same effect as reset, lower priority than iRSTn.
- iSTART  input  1  frame request; accepted only while oREADY=1.
- iHEADER  input  6  header value, sampled when iSTART is accepted.
- iDATA  input  DWL  payload value, sampled when iSTART is accepted.
- iBIT_EN  input  1  bit-rate strobe; one bit is transmitted per cycle in which it is high.
- oMOSI  output  1  serial data; bit 5 of the header is sent first.
- oBIT_VALID  output  1  high when oMOSI carries a bit consumed this cycle; drives the receiver's shift enable.
- oREADY  output  1  high in IDLE.
- oBUSY  output  1  high in HEADER, PAYLOAD or PARITY.
- oHEADER_DONE  output  1  one-cycle pulse on the 6th header bit.
- oDONE  output  1  one-cycle pulse on the last bit of the frame.

Behaviour:
- Reset and clear:
  - iRSTn=0 at a clock edge forces state IDLE, shift register 0, counter 0.
  - Outputs after reset: oMOSI=0, oBIT_VALID=0, oREADY=1, oBUSY=0, oHEADER_DONE=0, oDONE=0.
  - iCLR=1 (with iRSTn=1) gives the identical result, including mid-frame. The partial frame is abandoned, no oDONE is issued, and oBIT_VALID is 0 in that cycle.
- Storage:
  - Shift register SR, width 6+DWL, MSB = first bit out.
  - Counter CNT, width CWL.
- States: IDLE, HEADER, PAYLOAD, plus PARITY (only with the macro).
- IDLE:
  - On iSTART=1: SR <= {iHEADER, iDATA}, CNT <= 0, next state HEADER.
  - iBIT_EN is ignored in IDLE.
  - The first bit can be sent in the cycle after acceptance.
- Output timing:
  - oMOSI = SR[MSB] while busy, and 0 in IDLE.
  - oMOSI is registered-stable for the whole cycle.
  - oBIT_VALID = iBIT_EN AND oBUSY (combinational, same cycle).
- HEADER:
  - Each cycle with iBIT_EN=1: SR shifts left by one with zero fill, CNT increments.
  - When CNT==5 and iBIT_EN=1: oHEADER_DONE=1, CNT <= 0, next state PAYLOAD.
- PAYLOAD:
  - Same shift rule as HEADER.
  - When CNT==DWL-1 and iBIT_EN=1: oDONE=1, next state IDLE (or PARITY with the macro, in which case oDONE moves to the PARITY bit).
- Gaps: iBIT_EN=0 while busy holds SR, CNT and state; oMOSI is unchanged.
- iSTART while busy, or in the oDONE cycle: ignored, with no side effects and no queuing.
- Frame length: 6+DWL qualified strobes. With continuous iBIT_EN, oBUSY is high for exactly 6+DWL cycles.
- Receiver alignment: feeding oMOSI/oBIT_VALID into the receiver's MOSI/iEN makes its oHEADER equal iHEADER in the oHEADER_DONE cycle, and its header-enable pulse is coincident with oHEADER_DONE.
- iCLR and iSTART in the same cycle: clear wins and the frame is not accepted.

Optional Feature:
- Macro: SPI_TX_PARITY_EN.
- Defined:
  - An even-parity bit over header and payload, computed at acceptance, is held in a 1-bit register.
  - State PARITY follows PAYLOAD and sends this bit on the next iBIT_EN strobe.
  - oDONE pulses on the parity bit; frame = 7+DWL strobes.
- Undefined: no parity logic, no PARITY state; frame = 6+DWL strobes.

Test Plan:
- Basic frame: DWL=16, iHEADER=6'b101101, iDATA=16'hA5C3, iBIT_EN=1 continuously.
  - Expect oMOSI = 1,0,1,1,0,1 then 1010 0101 1100 0011.
  - oHEADER_DONE on strobe 6, oDONE on strobe 22, oREADY=1 on the following cycle.
- Loopback into the SPI slave header receiver: iHEADER=6'b010011.
  - Expect receiver oHEADER=6'b010011 with its header-enable pulse in the same cycle as oHEADER_DONE.
- Gapped strobe: iBIT_EN high every 3rd cycle, iHEADER=6'h3F, iDATA=16'h0001.
  - Expect oMOSI stable across gaps, oDONE 22 strobes (≈66 cycles) after start, and exactly 22 oBIT_VALID pulses.
- Mid-frame disruption: iCLR=1 after payload bit 4.
  - Expect IDLE next cycle, oMOSI=0, no oDONE.
  - iSTART during a busy frame changes nothing.
  - Repeat with iRSTn=0 mid-header: identical result.
- Back-to-back: iSTART asserted in the oDONE cycle is ignored; iSTART one cycle later is accepted and iHEADER is re-sampled.
- With SPI_TX_PARITY_EN: iHEADER=6'b000001, iDATA=16'h0003.
  - Expect a 23rd bit = 1 (three ones, even parity) and oDONE on strobe 23.

Source files
------------

// File: rtl/spi_header_serializer.sv
// ============================================================================
// Module   : spi_header_serializer
// Purpose  : Shifts a 6-bit header plus DWL-bit payload out MSB-first, one bit
//            per iBIT_EN strobe. Optional even-parity trailer: SPI_TX_PARITY_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_header_serializer #(
    parameter int DWL = 16,
    parameter int CWL = 5
) (
    input  logic           iCLK,
    input  logic           iRSTn,
    input  logic           iCLR,
    input  logic           iSTART,
    input  logic [5:0]     iHEADER,
    input  logic [DWL-1:0] iDATA,
    input  logic           iBIT_EN,
    output logic           oMOSI,
    output logic           oBIT_VALID,
    output logic           oREADY,
    output logic           oBUSY,
    output logic           oHEADER_DONE,
    output logic           oDONE
);

    localparam int FW = 6 + DWL;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HEADER  = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;
`ifdef SPI_TX_PARITY_EN
    localparam logic [1:0] S_PARITY  = 2'd3;
`endif

    localparam logic [CWL-1:0] C_HDR_LAST = CWL'(5);
    localparam logic [CWL-1:0] C_PAY_LAST = CWL'(DWL - 1);

    logic [1:0]     state_q, state_d;
    logic [FW-1:0]  sr_q, sr_d;
    logic [CWL-1:0] cnt_q, cnt_d;
    logic           busy;
    logic           strobe;
    logic           hdr_done;
    logic           done;
`ifdef SPI_TX_PARITY_EN
    logic           parity_q, parity_d;
`endif

    assign busy   = (state_q != S_IDLE);
    assign strobe = iBIT_EN & busy;

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        hdr_done = 1'b0;
        done     = 1'b0;
`ifdef SPI_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (iSTART) begin
                    sr_d    = {iHEADER, iDATA};
                    cnt_d   = '0;
                    state_d = S_HEADER;
`ifdef SPI_TX_PARITY_EN
                    parity_d = ^{iHEADER, iDATA};
`endif
                end
            end
            S_HEADER: begin
                if (strobe) begin
                    sr_d = {sr_q[FW-2:0], 1'b0};
                    if (cnt_q == C_HDR_LAST) begin
                        hdr_done = 1'b1;
                        cnt_d    = '0;
                        state_d  = S_PAYLOAD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_PAYLOAD: begin
                if (strobe) begin
                    sr_d = {sr_q[FW-2:0], 1'b0};
                    if (cnt_q == C_PAY_LAST) begin
                        cnt_d = '0;
`ifdef SPI_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        done    = 1'b1;
                        state_d = S_IDLE;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef SPI_TX_PARITY_EN
            S_PARITY: begin
                if (strobe) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Clear abandons any partial frame and suppresses its completion pulses.
        if (iCLR) begin
            state_d  = S_IDLE;
            sr_d     = '0;
            cnt_d    = '0;
            hdr_done = 1'b0;
            done     = 1'b0;
`ifdef SPI_TX_PARITY_EN
            parity_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRSTn) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
`ifdef SPI_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
`ifdef SPI_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

`ifdef SPI_TX_PARITY_EN
    assign oMOSI = (state_q == S_PARITY) ? parity_q : (busy ? sr_q[FW-1] : 1'b0);
`else
    assign oMOSI = busy ? sr_q[FW-1] : 1'b0;
`endif

    assign oBIT_VALID   = strobe & ~iCLR & iRSTn;
    assign oREADY       = ~busy;
    assign oBUSY        = busy;
    assign oHEADER_DONE = hdr_done & iRSTn;
    assign oDONE        = done & iRSTn;

endmodule

`default_nettype wire
